// File: rtl/stack_arbiter_if.sv
// Request/response and stack-side signals of the two-port stack arbiter.
// slave  : arbiter side (takes requests, drives stack strobes)
// master : requester/stack side (drives requests, stack status and pop data)
interface stack_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid, req1_valid;
  logic             req0_op,    req1_op;
  logic [WIDTH-1:0] req0_wdata, req1_wdata;
  logic             req0_ready, req1_ready;
  logic             req0_done,  req1_done;
  logic             req0_err,   req1_err;
  logic [WIDTH-1:0] req0_rdata, req1_rdata;
  logic             stack_push;
  logic             stack_pop;
  logic [WIDTH-1:0] stack_data_out;
  logic [WIDTH-1:0] stack_data_in;
  logic             stack_full;
  logic             stack_empty;
  logic             busy;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_wdata, req1_wdata,
    input  stack_data_in, stack_full, stack_empty,
    output req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err,
    output req0_rdata, req1_rdata, stack_push, stack_pop, stack_data_out, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_wdata, req1_wdata,
    output stack_data_in, stack_full, stack_empty,
    input  req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err,
    input  req0_rdata, req1_rdata, stack_push, stack_pop, stack_data_out, busy
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one hardware stack between two requesters.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - stack_arbiter_if.slave: per-port valid/ready request, done/err/rdata
//           response, stack push/pop strobes, push/pop data, full/empty status, busy
//
// state   | meaning
// IDLE    | ready offered to the selected port; accept latches the request
// CMD     | one-cycle push or pop strobe to the stack
// CAPTURE | stack pop data valid; registered into the response buffer
// RESP    | one-cycle done (with err/rdata) to the latched port
module stack_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  stack_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, CAPTURE, RESP} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             port_q, port_d;
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic sel;
  logic any_valid;
  logic sel_op;

  // Tie goes to prio; otherwise whichever single port is valid.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign sel       = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
  assign sel_op    = sel ? bus.req1_op : bus.req0_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      port_q  <= 1'b0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      port_q  <= port_d;
      op_q    <= op_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    port_d  = port_q;
    op_d    = op_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          port_d  = sel;
          op_d    = sel_op;
          wdata_d = sel ? bus.req1_wdata : bus.req0_wdata;
          prio_d  = ~sel;
          // full/empty judged once, at acceptance; later changes are ignored
          err_d   = sel_op ? bus.stack_empty : bus.stack_full;
          rdata_d = '0;
          state_d = (sel_op ? bus.stack_empty : bus.stack_full) ? RESP : CMD;
        end
      end
      CMD:     state_d = op_q ? CAPTURE : RESP;
      CAPTURE: begin
        rdata_d = bus.stack_data_in;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready     = 1'b0;
    bus.req1_ready     = 1'b0;
    bus.req0_done      = 1'b0;
    bus.req1_done      = 1'b0;
    bus.req0_err       = 1'b0;
    bus.req1_err       = 1'b0;
    bus.req0_rdata     = '0;
    bus.req1_rdata     = '0;
    bus.stack_push     = 1'b0;
    bus.stack_pop      = 1'b0;
    bus.stack_data_out = '0;
    bus.busy           = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        bus.req0_ready = bus.req0_valid & ~sel;
        bus.req1_ready = bus.req1_valid & sel;
      end
      CMD: begin
        bus.stack_push     = ~op_q;
        bus.stack_pop      = op_q;
        bus.stack_data_out = op_q ? '0 : wdata_q;
      end
      RESP: begin
        // rdata_q is cleared at acceptance, so push/error responses carry 0
        if (port_q) begin
          bus.req1_done  = 1'b1;
          bus.req1_err   = err_q;
          bus.req1_rdata = rdata_q;
        end else begin
          bus.req0_done  = 1'b1;
          bus.req0_err   = err_q;
          bus.req0_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  stack_arbiter_if #(.WIDTH(8)) bus();

  stack_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Small stack model: push stores, pop returns the top entry one cycle later.
  logic [7:0] mem [16];
  int         sp = 0;
  logic [7:0] data_in_q = 8'h00;
  assign bus.stack_data_in = data_in_q;

  always @(posedge clk) begin
    if (bus.stack_push) begin
      mem[sp[3:0]] <= bus.stack_data_out;
      sp <= sp + 1;
    end
    if (bus.stack_pop) begin
      data_in_q <= mem[(sp - 1) & 15];
      sp <= sp - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_wdata = 8'h00;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_wdata = 8'h00;
    bus.stack_full = 0; bus.stack_empty = 1;

    // reset state
    tick(); tick();
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_push", bus.stack_push, 0);
    chk("rst_pop", bus.stack_pop, 0);
    chk("rst_done0", bus.req0_done, 0);
    chk("rst_data_out", bus.stack_data_out, 0);
    reset = 0;

    // port 0 pushes 0x5A
    bus.req0_valid = 1; bus.req0_op = 0; bus.req0_wdata = 8'h5A;
    #1;
    chk("push_ready0", bus.req0_ready, 1);
    chk("push_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    #1;
    chk("push_strobe", bus.stack_push, 1);
    chk("push_data", bus.stack_data_out, 8'h5A);
    chk("push_busy", bus.busy, 1);
    chk("push_early_done", bus.req0_done, 0);
    tick(); #1;
    chk("push_done0", bus.req0_done, 1);
    chk("push_err0", bus.req0_err, 0);
    chk("push_rdata0", bus.req0_rdata, 0);
    chk("push_strobe_off", bus.stack_push, 0);
    bus.stack_empty = 0;
    tick(); #1;
    chk("push_idle", bus.busy, 0);

    // port 1 pops 0x5A
    bus.req1_valid = 1; bus.req1_op = 1;
    #1;
    chk("pop_ready1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    #1;
    chk("pop_strobe", bus.stack_pop, 1);
    chk("pop_no_push", bus.stack_push, 0);
    tick(); #1;
    chk("pop_capture_nodone", bus.req1_done, 0);
    chk("pop_capture_popoff", bus.stack_pop, 0);
    tick(); #1;
    chk("pop_done1", bus.req1_done, 1);
    chk("pop_rdata1", bus.req1_rdata, 8'h5A);
    chk("pop_err1", bus.req1_err, 0);
    chk("pop_done0", bus.req0_done, 0);
    tick();

    // both ports continuously valid: grants alternate 0,1,0,1
    bus.req0_valid = 1; bus.req0_op = 0; bus.req0_wdata = 8'h01;
    bus.req1_valid = 1; bus.req1_op = 0; bus.req1_wdata = 8'h02;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt%0d_ready0", k), bus.req0_ready, (k % 2) == 0);
      chk($sformatf("alt%0d_ready1", k), bus.req1_ready, (k % 2) == 1);
      tick(); #1;
      chk($sformatf("alt%0d_push", k), bus.stack_push, 1);
      chk($sformatf("alt%0d_pop", k), bus.stack_pop, 0);
      chk($sformatf("alt%0d_data", k), bus.stack_data_out, ((k % 2) == 0) ? 8'h01 : 8'h02);
      tick(); #1;
      chk($sformatf("alt%0d_done0", k), bus.req0_done, (k % 2) == 0);
      chk($sformatf("alt%0d_done1", k), bus.req1_done, (k % 2) == 1);
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();

    // pop on empty from port 0: error, no strobe
    bus.stack_empty = 1;
    bus.req0_valid = 1; bus.req0_op = 1;
    #1;
    chk("perr_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    #1;
    chk("perr_done0", bus.req0_done, 1);
    chk("perr_err0", bus.req0_err, 1);
    chk("perr_rdata0", bus.req0_rdata, 0);
    chk("perr_pop", bus.stack_pop, 0);
    tick(); #1;
    chk("perr_pop_after", bus.stack_pop, 0);
    chk("perr_idle", bus.busy, 0);
    bus.stack_empty = 0;

    // push on full from port 1: error, then retry succeeds
    bus.stack_full = 1;
    bus.req1_valid = 1; bus.req1_op = 0; bus.req1_wdata = 8'hFF;
    tick();
    bus.req1_valid = 0;
    #1;
    chk("ferr_done1", bus.req1_done, 1);
    chk("ferr_err1", bus.req1_err, 1);
    chk("ferr_push", bus.stack_push, 0);
    tick();
    bus.stack_full = 0;
    bus.req1_valid = 1;
    #1;
    chk("retry_ready1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    #1;
    chk("retry_push", bus.stack_push, 1);
    chk("retry_data", bus.stack_data_out, 8'hFF);
    tick(); #1;
    chk("retry_done1", bus.req1_done, 1);
    chk("retry_err1", bus.req1_err, 0);
    tick();

    // reset during the CMD cycle of a pop; leaves prio at 1 beforehand
    bus.req0_valid = 1; bus.req0_op = 1;
    tick();
    bus.req0_valid = 0;
    #1;
    chk("rcmd_pop", bus.stack_pop, 1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rcmd_busy", bus.busy, 0);
    chk("rcmd_done0", bus.req0_done, 0);
    chk("rcmd_pop_off", bus.stack_pop, 0);
    tick(); #1;
    chk("rcmd_no_done0", bus.req0_done, 0);
    chk("rcmd_no_done1", bus.req1_done, 0);

    // tie after reset goes to port 0
    bus.req0_valid = 1; bus.req0_op = 0; bus.req0_wdata = 8'h33;
    bus.req1_valid = 1; bus.req1_op = 0; bus.req1_wdata = 8'h44;
    #1;
    chk("rprio_ready0", bus.req0_ready, 1);
    chk("rprio_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    chk("rprio_push", bus.stack_push, 1);
    chk("rprio_data", bus.stack_data_out, 8'h33);
    tick(); #1;
    chk("rprio_done0", bus.req0_done, 1);
    chk("rprio_err0", bus.req0_err, 0);
    tick(); #1;
    chk("rprio_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
